// File: rtl/counter_chain_driver.sv
// Sequencer for a cascade of 4-bit up/down counter stages: parallel loads and
// N-step count runs, with an optional halt at the chain's terminal count.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | waiting for a command; cmd_ready high
//  S_LOAD  | load low for one cycle, chain takes d at the closing edge
//  S_SETUP | ud already written, one quiet cycle for rco to settle
//  S_COUNT | one chain step per cycle until remaining runs out or tc halt
//  S_DONE  | one-cycle done pulse, tc_stop valid alongside it
module counter_chain_driver #(
   parameter int STAGES = 2,
   parameter int CNT_W  = 8,
   localparam int W     = 4 * STAGES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [W-1:0]     cmd_data,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             cmd_stop_tc,
   output logic             load,
   output logic             ud,
   output logic [W-1:0]     d,
   output logic             enp,
   output logic             ent,
   input  logic             rco,
   output logic             busy,
   output logic             done,
   output logic             tc_stop,
   output logic [CNT_W-1:0] steps_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_COUNT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             load_q, load_d;
   logic             ud_q, ud_d;
   logic [W-1:0]     d_q, d_d;
   logic             stop_tc_q, stop_tc_d;
   logic             tc_stop_q, tc_stop_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] steps_done_q, steps_done_d;
   logic             step;

   always_comb begin
      state_d      = state_q;
      load_d       = load_q;
      ud_d         = ud_q;
      d_d          = d_q;
      stop_tc_d    = stop_tc_q;
      tc_stop_d    = tc_stop_q;
      remaining_d  = remaining_q;
      steps_done_d = steps_done_q;
      step         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               stop_tc_d    = cmd_stop_tc;
               remaining_d  = cmd_steps;
               steps_done_d = '0;
               tc_stop_d    = 1'b0;
               case (cmd_op)
                  2'b00: begin
                     d_d     = cmd_data;
                     load_d  = 1'b0;
                     state_d = S_LOAD;
                  end
                  2'b01: begin
                     ud_d    = 1'b1;
                     state_d = S_SETUP;
                  end
                  2'b10: begin
                     ud_d    = 1'b0;
                     state_d = S_SETUP;
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_LOAD: begin
            load_d  = 1'b1;
            state_d = S_DONE;
         end
         S_SETUP: begin
            state_d = (remaining_q == '0) ? S_DONE : S_COUNT;
         end
         S_COUNT: begin
            // rco low means the next step would wrap; honour stop_tc before stepping
            if (stop_tc_q && !rco) begin
               tc_stop_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               step         = 1'b1;
               steps_done_d = steps_done_q + CNT_W'(1);
               remaining_d  = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         load_q       <= 1'b1;
         ud_q         <= 1'b1;
         d_q          <= '0;
         stop_tc_q    <= 1'b0;
         tc_stop_q    <= 1'b0;
         remaining_q  <= '0;
         steps_done_q <= '0;
      end else begin
         state_q      <= state_d;
         load_q       <= load_d;
         ud_q         <= ud_d;
         d_q          <= d_d;
         stop_tc_q    <= stop_tc_d;
         tc_stop_q    <= tc_stop_d;
         remaining_q  <= remaining_d;
         steps_done_q <= steps_done_d;
      end
   end

   assign load       = load_q;
   assign ud         = ud_q;
   assign d          = d_q;
   assign enp        = ~step;
   assign ent        = ~step;
   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign tc_stop    = tc_stop_q;
   assign steps_done = steps_done_q;

endmodule

// File: tb/tb_counter_chain_driver.sv
// Bench for counter_chain_driver: behavioural counter chain plus an arithmetic
// reference of each command's result, directed cases and random commands.
module tb_counter_chain_driver;
   localparam int STAGES = 2;
   localparam int CNT_W  = 8;
   localparam int W      = 4 * STAGES;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b11;
   logic [W-1:0]     cmd_data = '0;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic             cmd_stop_tc = 1'b0;
   logic             load, ud, enp, ent, rco, busy, done, tc_stop;
   logic [W-1:0]     d;
   logic [CNT_W-1:0] steps_done;

   logic [W-1:0]     chain_val = '0;
   logic [W-1:0]     ref_val = '0;
   int               vectors = 0;
   int               miscompares = 0;

   always #5 clock = ~clock;

   counter_chain_driver #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
      .cmd_stop_tc(cmd_stop_tc), .load(load), .ud(ud), .d(d), .enp(enp),
      .ent(ent), .rco(rco), .busy(busy), .done(done), .tc_stop(tc_stop),
      .steps_done(steps_done)
   );

   // Whole chain as one W-bit counter; rco reflects terminal count for the
   // current direction regardless of ent, keeping the enable path acyclic.
   assign rco = ud ? (chain_val != {W{1'b1}}) : (chain_val != '0);

   always @(posedge clock) begin
      if (!load)             chain_val <= d;
      else if (!enp && !ent) chain_val <= ud ? chain_val + W'(1) : chain_val - W'(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   // Issue one command, predict its outcome from the rules, check on completion.
   task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [CNT_W-1:0] steps, input logic stop);
      logic [W-1:0] v, term;
      int exp_steps, exp_lat, lat, enp_lows, load_lows;
      logic exp_tc, seen;
      v = ref_val; exp_steps = 0; exp_tc = 1'b0; exp_lat = 1;
      term = (op == 2'd1) ? {W{1'b1}} : '0;
      case (op)
         2'd0: begin v = data; exp_lat = 2; end
         2'd1, 2'd2: begin
            for (int i = 0; i < int'(steps); i++) begin
               if (stop && v == term) begin exp_tc = 1'b1; break; end
               v = (op == 2'd1) ? v + W'(1) : v - W'(1);
               exp_steps++;
            end
            exp_lat = 2 + exp_steps + int'(exp_tc);
         end
         default: exp_lat = 1;
      endcase

      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps; cmd_stop_tc = stop;
      @(negedge clock);
      cmd_valid = 1'b0; cmd_op = 2'b11;
      lat = 0; enp_lows = 0; load_lows = 0; seen = 1'b0;
      while (!seen && lat < exp_lat + 20) begin
         lat++;
         chk("ready_low_busy", 32'(cmd_ready), 32'd0);
         chk("ent_eq_enp", 32'(ent), 32'(enp));
         if (!enp) enp_lows++;
         if (!load) begin
            load_lows++;
            chk("load_data", 32'(d), 32'(data));
         end
         if (done) seen = 1'b1;
         else @(negedge clock);
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_latency", 32'(lat), 32'(exp_lat));
      chk("tc_stop", 32'(tc_stop), 32'(exp_tc));
      chk("steps_done", 32'(steps_done), 32'(exp_steps));
      chk("step_cycles", 32'(enp_lows), 32'(exp_steps));
      chk("load_cycles", 32'(load_lows), (op == 2'd0) ? 32'd1 : 32'd0);
      @(negedge clock);
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("chain_value", 32'(chain_val), 32'(v));
      if (op == 2'd1 || op == 2'd2) chk("ud_dir", 32'(ud), (op == 2'd1) ? 32'd1 : 32'd0);
      ref_val = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, g, dones, extra, lat;
      logic [W-1:0] t;

      repeat (3) @(negedge clock);
      reset = 1'b1;
      chk("rst_load", 32'(load), 32'd1);
      chk("rst_ud", 32'(ud), 32'd1);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_enp", 32'(enp), 32'd1);
      chk("rst_ent", 32'(ent), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tc_stop", 32'(tc_stop), 32'd0);
      chk("rst_steps_done", 32'(steps_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);

      // Directed cases from the plan
      do_cmd(2'd0, 8'h3C, 8'd0, 1'b0);
      do_cmd(2'd1, 8'h00, 8'd5, 1'b0);
      chk("tp_up_value", 32'(chain_val), 32'h41);
      chk("tp_up_steps", 32'(steps_done), 32'd5);
      do_cmd(2'd0, 8'h02, 8'd0, 1'b0);
      do_cmd(2'd2, 8'h00, 8'd5, 1'b1);
      chk("tp_stop_value", 32'(chain_val), 32'h00);
      chk("tp_stop_steps", 32'(steps_done), 32'd2);
      chk("tp_stop_flag", 32'(tc_stop), 32'd1);
      do_cmd(2'd0, 8'h02, 8'd0, 1'b0);
      chk("tp_flag_cleared", 32'(tc_stop), 32'd0);
      do_cmd(2'd2, 8'h00, 8'd5, 1'b0);
      chk("tp_wrap_value", 32'(chain_val), 32'hFD);
      chk("tp_wrap_flag", 32'(tc_stop), 32'd0);
      do_cmd(2'd1, 8'h00, 8'd0, 1'b1);
      chk("tp_zero_value", 32'(chain_val), 32'hFD);
      do_cmd(2'd3, 8'h55, 8'd9, 1'b0);
      do_cmd(2'd0, 8'hFE, 8'd0, 1'b0);
      do_cmd(2'd1, 8'h00, 8'd4, 1'b1);
      chk("tp_up_stop_value", 32'(chain_val), 32'hFF);

      // Reset in the middle of a long run
      do_cmd(2'd0, 8'h20, 8'd0, 1'b0);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_steps = 8'd100; cmd_stop_tc = 1'b0;
      @(negedge clock);
      cmd_valid = 1'b0; cmd_op = 2'b11;
      n = 0; g = 0; dones = 0;
      while (n < 10 && g < 300) begin
         @(negedge clock);
         g++;
         if (!enp) n++;
         if (done) dones++;
      end
      chk("rst_run_steps", 32'(n), 32'd10);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_enp", 32'(enp), 32'd1);
      chk("midrst_ent", 32'(ent), 32'd1);
      chk("midrst_steps_done", 32'(steps_done), 32'd0);
      repeat (3) begin
         if (done) dones++;
         @(negedge clock);
      end
      chk("midrst_no_done", 32'(dones), 32'd0);
      chk("midrst_chain", 32'(chain_val), 32'h2A);
      ref_val = 8'h2A;
      do_cmd(2'd0, 8'h77, 8'd0, 1'b0);

      // cmd_valid held high with changing ops during a run
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_steps = 8'd6; cmd_stop_tc = 1'b0;
      @(negedge clock);
      extra = 0; lat = 0;
      while (!done && lat < 50) begin
         lat++;
         if (cmd_ready) extra++;
         cmd_op = 2'($urandom_range(0, 3));
         cmd_steps = CNT_W'($urandom_range(0, 255));
         cmd_data = W'($urandom);
         @(negedge clock);
      end
      lat++;
      cmd_op = 2'd3;
      chk("busy_latency", 32'(lat), 32'd8);
      chk("busy_extra_accepts", 32'(extra), 32'd0);
      @(negedge clock);
      chk("busy_next_ready", 32'(cmd_ready), 32'd1);
      @(negedge clock);
      cmd_valid = 1'b0;
      chk("busy_second_done", 32'(done), 32'd1);
      chk("busy_chain", 32'(chain_val), 32'h7D);
      ref_val = 8'h7D;
      @(negedge clock);

      // Random commands, biased toward both terminal counts
      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0: t = W'($urandom);
            1: t = W'($urandom_range(0, 3));
            default: begin
               t = '1;
               t = t - W'($urandom_range(0, 3));
            end
         endcase
         do_cmd(op, t, CNT_W'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
